// File: rtl/uart_wb_bridge.sv
// rtl/uart_wb_bridge.sv - Wishbone classic slave front-end for the UART register file
// Byte-lane steering, optional wide access, programmable wait states and error termination.
module uart_wb_bridge #(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int WAIT_STATES = 0,
  parameter int WIDE_EN     = 1
) (
  input  logic            clk,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic [AW-1:0]   reg_adr_o,
  output logic [7:0]      reg_dat8_o,
  input  logic [7:0]      reg_dat8_i,
  input  logic [DW-1:0]   reg_datw_i,
  output logic            wide_o,
  output logic            we_o,
  output logic            re_o
);
  localparam int LANES = DW / 8;
  localparam int LB    = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int LBW   = (LB > 0) ? LB : 1;
  localparam logic [AW-1:0] LANE_MASK = AW'(LANES - 1);
  localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, ERR} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [LBW-1:0]  lane_q, lane_d;
  logic            write_q, write_d;
  logic            wide_q, wide_d;
  logic [AW-1:0]   reg_adr_q, reg_adr_d;
  logic [7:0]      reg_dat8_q, reg_dat8_d;
  logic [DW-1:0]   dat_q, dat_d;

  logic            hit;
  logic            sel_one;
  logic            sel_all;
  logic [LBW-1:0]  lane_k;

  always_comb begin
    hit     = wb_cyc_i & wb_stb_i;
    sel_one = (wb_sel_i != '0) && ((wb_sel_i & (wb_sel_i - 1'b1)) == '0);
    sel_all = &wb_sel_i;
    lane_k  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (wb_sel_i[i]) lane_k = LBW'(i);
    end

    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    write_d    = write_q;
    wide_d     = wide_q;
    reg_adr_d  = reg_adr_q;
    reg_dat8_d = reg_dat8_q;
    dat_d      = dat_q;
    wb_ack_o   = 1'b0;
    wb_err_o   = 1'b0;
    we_o       = 1'b0;
    re_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          if (sel_one) begin
            state_d    = ACCESS;
            reg_adr_d  = (wb_adr_i & ~LANE_MASK) | AW'(lane_k);
            reg_dat8_d = wb_dat_i[8*lane_k +: 8];
            lane_d     = lane_k;
            wide_d     = 1'b0;
            write_d    = wb_we_i;
          end else if (sel_all && (WIDE_EN != 0)) begin
            state_d    = ACCESS;
            reg_adr_d  = wb_adr_i & ~LANE_MASK;
            reg_dat8_d = wb_dat_i[7:0];
            lane_d     = '0;
            wide_d     = 1'b1;
            write_d    = wb_we_i;
          end else begin
            // Cleared on entry so the error beat already carries zero data.
            state_d = ERR;
            dat_d   = '0;
          end
        end
      end
      ACCESS: begin
        we_o = write_q;
        re_o = ~write_q;
        if (!write_q) begin
          dat_d = wide_q ? reg_datw_i : (DW'(reg_dat8_i) << (8 * lane_q));
        end
        cnt_d = '0;
        if (!wb_cyc_i)             state_d = IDLE;
        else if (WAIT_STATES > 0)  state_d = WAIT;
        else                       state_d = RESP;
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WS_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        wb_ack_o = hit;
        state_d  = IDLE;
      end
      ERR: begin
        wb_err_o = hit;
        dat_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lane_q     <= '0;
      write_q    <= 1'b0;
      wide_q     <= 1'b0;
      reg_adr_q  <= '0;
      reg_dat8_q <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      write_q    <= write_d;
      wide_q     <= wide_d;
      reg_adr_q  <= reg_adr_d;
      reg_dat8_q <= reg_dat8_d;
      dat_q      <= dat_d;
    end
  end

  // wide_o is qualified by state so it reads 0 whenever no access is in flight.
  assign wide_o     = wide_q & (state_q != IDLE) & (state_q != ERR);
  assign reg_adr_o  = reg_adr_q;
  assign reg_dat8_o = reg_dat8_q;
  assign wb_dat_o   = dat_q;
endmodule
